vga_sync_receptor: RTL and testbench
====================================

VGA_SYNC_RECEPTOR -- requirements
Module: vga_sync_receptor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pixel clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port hsync, input, 1 bit: active-low horizontal sync, low for x 656..751 of an 800-pixel line.
REQ-004 SHALL have port vsync, input, 1 bit: active-low vertical sync, low for lines 490..491 of a 525-line frame.
REQ-005 SHALL have port video_on, input, 1 bit: active-high visible-area flag from the transmitter.
REQ-006 SHALL have port x, output, 10 bits: recovered column 0..799.
REQ-007 SHALL have port y, output, 10 bits: recovered line 0..524.
REQ-008 SHALL have port pixel_valid, output, 1 bit: locked and x<640 and y<480.
REQ-009 SHALL have port locked, output, 1 bit: timing lock acquired.
REQ-010 SHALL have port frame_start, output, 1 bit: one-cycle pulse when locked and (x,y)=(0,0).
REQ-011 SHALL have port sync_err, output, 1 bit: one-cycle pulse on any timing violation.
REQ-012 SHALL have port err_count, output, 8 bits: saturating count of sync_err pulses.

Function
REQ-013 SHALL register hsync, vsync and video_on in two stages; falling edge = stage2 high and stage1 low.
REQ-014 SHALL make outputs describe the input sample taken 2 clocks earlier (fixed 2-cycle latency).
REQ-015 SHALL keep a column counter that wraps 799->0 and a line counter that increments on column wrap and wraps 524->0.
REQ-016 SHALL implement FSM states SEARCH, LINE, LOCKED.
REQ-017 SEARCH: x=0, y=0. hsync fall -> load x=656 and go to LINE.
REQ-018 LINE: column counter runs and y holds 0. A hsync fall with predicted x!=656 reloads x=656 and stays in LINE. A vsync fall with predicted x==0 loads y=490 and goes to LOCKED. A vsync fall with x!=0 goes to SEARCH.
REQ-019 LOCKED violations: hsync fall at x!=656; predicted x==656 with no hsync fall; vsync fall at (x,y)!=(0,490); predicted (0,490) with no vsync fall.
REQ-020 SHALL, on any REQ-019 violation, pulse sync_err the same cycle, go to SEARCH and drop locked the next cycle.
REQ-021 SHALL drive locked=1 only in LOCKED; pixel_valid and frame_start SHALL be 0 outside LOCKED.
REQ-022 SHALL increment err_count per sync_err pulse, saturating at 255.
REQ-023 When hsync and vsync fall in the same sample in LINE, SHALL apply the hsync rule first, then evaluate vsync against the reloaded x=656 (i.e., go to SEARCH).

Reset
REQ-024 SHALL, while reset=1 at a clock edge, force: state SEARCH, x=0, y=0, pixel_valid=0, locked=0, frame_start=0, sync_err=0, err_count=0, sync history registers=1.
REQ-025 SHALL treat reset asserted mid-frame identically to power-up; lock SHALL be reacquired from scratch.

Configuration
REQ-026 With VGA_RX_DE_CHECK_EN defined, in LOCKED a mismatch between registered video_on and (x<640 and y<480) SHALL be an additional REQ-019 violation.
REQ-027 Without VGA_RX_DE_CHECK_EN, video_on SHALL be ignored and no logic SHALL depend on it.

Verification
REQ-028 Reset, then nominal 800x525 stream from 2 frames -> locked=1 after first vsync fall; x/y match source delayed 2 cycles; frame_start pulses once per 420000 cycles.
REQ-029 Locked, one hsync fall delivered at x=660 -> sync_err pulse, locked=0 next cycle, err_count=1; relocks at next vsync.
REQ-030 Locked, vsync held high for one frame -> sync_err at predicted (0,490), state SEARCH.
REQ-031 Locked with VGA_RX_DE_CHECK_EN, video_on forced 0 at (100,100) -> sync_err; without the macro -> no error, locked stays 1.
REQ-032 300 injected violations -> err_count=255, no wrap.
REQ-033 reset pulsed at (400,200) while locked -> all outputs 0 next cycle; relock after next vsync fall.

Source files
------------

// File: rtl/vga_sync_receptor.sv
// VGA 800x525 timing receptor: recovers (x,y) from hsync/vsync, tracks lock and counts timing errors.
// Optional macro VGA_RX_DE_CHECK_EN adds a video_on vs. raster-position check while locked.
module vga_sync_receptor (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_count
);
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] H_FALL = 10'd656;
  localparam logic [9:0] V_FALL = 10'd490;
  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] V_VIS  = 10'd480;

  typedef enum logic [1:0] {SEARCH = 2'd0, LINE = 2'd1, LOCKED = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [1:0] hs_pipe, vs_pipe;
  logic       h_fall, v_fall;
  logic       x_wrap;
  logic [9:0] x_pred, y_pred, x_nxt, y_nxt;
  logic       h_bad, v_bad, de_bad, viol;

  // [0] holds the newest sample, [1] the one before it
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe <= 2'b11;
      vs_pipe <= 2'b11;
    end else begin
      hs_pipe <= {hs_pipe[0], hsync};
      vs_pipe <= {vs_pipe[0], vsync};
    end
  end

  assign h_fall = hs_pipe[1] & ~hs_pipe[0];
  assign v_fall = vs_pipe[1] & ~vs_pipe[0];

  // Position the newest sample should have if the timing is intact
  assign x_wrap = (x == H_LAST);
  assign x_pred = x_wrap ? 10'd0 : x + 10'd1;
  assign y_pred = !x_wrap ? y : ((y == V_LAST) ? 10'd0 : y + 10'd1);

`ifdef VGA_RX_DE_CHECK_EN
  // Only the stage aligned with the sample under evaluation is needed here
  logic de_q;
  always_ff @(posedge clk) begin
    if (reset) de_q <= 1'b1;
    else       de_q <= video_on;
  end
  assign de_bad = de_q != ((x_pred < H_VIS) && (y_pred < V_VIS));
`else
  logic unused_video_on;
  assign unused_video_on = video_on;
  assign de_bad = 1'b0;
`endif

  // Each sync edge must land exactly on its predicted slot, and vice versa
  assign h_bad = h_fall != (x_pred == H_FALL);
  assign v_bad = v_fall != ((x_pred == 10'd0) && (y_pred == V_FALL));
  assign viol  = (state == LOCKED) && (h_bad || v_bad || de_bad);

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEARCH: if (h_fall) state_nxt = LINE;
      // hsync is applied first: a coincident hsync fall puts x at 656, never 0
      LINE:   if (v_fall) state_nxt = (!h_fall && x_pred == 10'd0) ? LOCKED : SEARCH;
      LOCKED: if (viol) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    x_nxt = 10'd0;
    y_nxt = 10'd0;
    unique case (state)
      SEARCH: if (h_fall) x_nxt = H_FALL;
      LINE: begin
        x_nxt = h_fall ? H_FALL : x_pred;
        if (v_fall) begin
          if (state_nxt == LOCKED) y_nxt = V_FALL;
          else                     x_nxt = 10'd0;
        end
      end
      LOCKED: if (!viol) begin
        x_nxt = x_pred;
        y_nxt = y_pred;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= 10'd0;
      y         <= 10'd0;
      sync_err  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      x        <= x_nxt;
      y        <= y_nxt;
      sync_err <= viol;
      if (viol && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    locked      = (state == LOCKED);
    pixel_valid = locked && (x < H_VIS) && (y < V_VIS);
    frame_start = locked && (x == 10'd0) && (y == 10'd0);
  end

endmodule

// File: tb/tb_vga_sync_receptor.sv
// Directed bench for vga_sync_receptor: a raster source with per-sample sync/DE overrides.
module tb_vga_sync_receptor;
  logic       clk = 1'b0;
  logic       reset, hsync, vsync, video_on;
  logic [9:0] x, y;
  logic       pixel_valid, locked, frame_start, sync_err;
  logic [7:0] err_count;

  int total = 0, bad = 0;
  int sx = 0, sy = 0;                 // position of the next sample to drive
  int h1x = -1, h1y = -1, h2x = -1, h2y = -1;
  int hp_x = -1, hp_y = -1;           // hsync forced low at this sample
  int hh_y = -1, hh_x0 = -1, hh_x1 = -1;
  int vp_x = -1, vp_y = -1;           // vsync forced low at this sample
  int dp_x = -1, dp_y = -1;           // video_on forced low at this sample
  int exp_err = 0;

`ifdef VGA_RX_DE_CHECK_EN
  localparam int DE_PULSES = 1;
`else
  localparam int DE_PULSES = 0;
`endif

  vga_sync_receptor dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .pixel_valid(pixel_valid), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Drive one sample, clock it, then look #1 later; outputs then describe (h2x,h2y)
  task automatic tick();
    hsync = !(sx >= 656 && sx <= 751);
    if (sx == hp_x && sy == hp_y) hsync = 1'b0;
    if (sy == hh_y && sx >= hh_x0 && sx <= hh_x1) hsync = 1'b1;
    vsync = !(sy == 490 || sy == 491);
    if (sx == vp_x && sy == vp_y) vsync = 1'b0;
    video_on = (sx < 640) && (sy < 480) && !(sx == dp_x && sy == dp_y);
    @(posedge clk);
    #1;
    h2x = h1x; h2y = h1y; h1x = sx; h1y = sy;
    if (sx == 799) begin sx = 0; sy = (sy == 524) ? 0 : sy + 1; end
    else sx = sx + 1;
  endtask

  task automatic relock(output bit ok);
    ok = 1'b0;
    sx = 655; sy = 489;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (locked) ok = 1'b1;
    end
  endtask

  task automatic run_to(input int tx, input int ty, input int budget,
                        output int pulses, output int ex, output int ey, output bit reached);
    pulses = 0; ex = -1; ey = -1; reached = 1'b0;
    for (int i = 0; i < budget && !reached; i++) begin
      tick();
      if (sync_err) begin pulses++; ex = h2x; ey = h2y; end
      if (h2x == tx && h2y == ty) reached = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sx = 0; sy = 0;
    repeat (3) tick();
    total++; if ({x, y} !== 20'd0) begin bad++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y); end
    total++; if ({locked, pixel_valid, frame_start, sync_err} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got lk=%b pv=%b fs=%b se=%b want 0", locked, pixel_valid, frame_start, sync_err);
    end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", err_count); end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    bit ok, reached, fs_pos;
    int bad_xy, bad_ctl, fs_n;
    relock(ok);
    total++; if (!ok) begin bad++; $display("FAIL lock_acquire: got locked=0 want 1"); end
    total++; if (x !== 10'd0 || y !== 10'd490) begin bad++; $display("FAIL lock_pos: got x=%0d y=%0d want 0 490", x, y); end
    bad_xy = 0; bad_ctl = 0; fs_n = 0; fs_pos = 1'b0; reached = 1'b0;
    for (int i = 0; i < 30000 && !reached; i++) begin
      tick();
      if (x !== h2x[9:0] || y !== h2y[9:0]) bad_xy++;
      if (locked !== 1'b1 || sync_err !== 1'b0 || pixel_valid !== (h2x < 640 && h2y < 480)) bad_ctl++;
      if (frame_start === 1'b1) begin fs_n++; fs_pos = (h2x == 0 && h2y == 0); end
      if (h2x == 10 && h2y == 0) reached = 1'b1;
    end
    total++; if (!reached) begin bad++; $display("FAIL sweep_timeout: got no (10,0) want reached"); end
    total++; if (bad_xy != 0) begin bad++; $display("FAIL sweep_xy: got %0d bad cycles want 0", bad_xy); end
    total++; if (bad_ctl != 0) begin bad++; $display("FAIL sweep_flags: got %0d bad cycles want 0", bad_ctl); end
    total++; if (fs_n != 1 || !fs_pos) begin bad++; $display("FAIL frame_start: got %0d pulses at00=%b want 1 at (0,0)", fs_n, fs_pos); end
  endtask

  task automatic test_de();
    int p, ex, ey; bit reached;
    dp_x = 100; dp_y = 1;
    run_to(120, 1, 1200, p, ex, ey, reached);
    dp_x = -1; dp_y = -1;
    exp_err += DE_PULSES;
    total++; if (!reached || p != DE_PULSES) begin bad++; $display("FAIL de_err: got %0d pulses want %0d", p, DE_PULSES); end
    total++; if (locked !== (DE_PULSES == 0)) begin bad++; $display("FAIL de_locked: got %b want %b", locked, DE_PULSES == 0); end
  endtask

  task automatic test_hsync_extra();
    int p, ex, ey; bit ok, reached;
    if (!locked) relock(ok);
    hp_x = sx + 5; hp_y = sy;
    run_to(hp_x + 10, hp_y, 40, p, ex, ey, reached);
    exp_err++;
    total++; if (p != 1 || ex != hp_x || ey != hp_y) begin
      bad++; $display("FAIL hx_err: got %0d pulses at (%0d,%0d) want 1 at (%0d,%0d)", p, ex, ey, hp_x, hp_y);
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL hx_locked: got %b want 0", locked); end
    total++; if (err_count !== exp_err[7:0]) begin bad++; $display("FAIL hx_cnt: got %0d want %0d", err_count, exp_err); end
    hp_x = -1; hp_y = -1;
  endtask

  task automatic test_hsync_late();
    int p, ex, ey; bit ok, reached;
    relock(ok);
    hh_y = 490; hh_x0 = 656; hh_x1 = 659;
    run_to(700, 490, 1000, p, ex, ey, reached);
    hh_y = -1;
    exp_err++;
    total++; if (!ok || p != 1 || ex != 656 || ey != 490) begin
      bad++; $display("FAIL hl_err: got %0d pulses at (%0d,%0d) want 1 at (656,490)", p, ex, ey);
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL hl_locked: got %b want 0", locked); end
    total++; if (err_count !== exp_err[7:0]) begin bad++; $display("FAIL hl_cnt: got %0d want %0d", err_count, exp_err); end
    relock(ok);
    total++; if (!ok) begin bad++; $display("FAIL hl_relock: got locked=0 want 1"); end
  endtask

  task automatic test_vsync_spurious();
    int p, ex, ey; bit ok, reached;
    if (!locked) relock(ok);
    vp_x = 20; vp_y = 492;
    run_to(40, 492, 2000, p, ex, ey, reached);
    vp_x = -1; vp_y = -1;
    exp_err++;
    total++; if (p != 1 || ex != 20 || ey != 492) begin
      bad++; $display("FAIL vs_err: got %0d pulses at (%0d,%0d) want 1 at (20,492)", p, ex, ey);
    end
    total++; if (err_count !== exp_err[7:0]) begin bad++; $display("FAIL vs_cnt: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_reset_mid();
    int p, ex, ey; bit ok, reached;
    relock(ok);
    run_to(400, 490, 600, p, ex, ey, reached);
    total++; if (!reached || locked !== 1'b1) begin bad++; $display("FAIL rm_pre: got locked=%b want 1", locked); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err = 0;
    total++; if ({x, y, locked, pixel_valid, frame_start, sync_err, err_count} !== 32'd0) begin
      bad++; $display("FAIL rm_clear: got x=%0d y=%0d lk=%b se=%b cnt=%0d want all 0", x, y, locked, sync_err, err_count);
    end
    relock(ok);
    total++; if (!ok || x !== 10'd0 || y !== 10'd490) begin bad++; $display("FAIL rm_relock: got lk=%b x=%0d y=%0d want 1 0 490", ok, x, y); end
  endtask

  task automatic test_saturation();
    bit ok, got;
    int seen = 0, c255 = -1;
    for (int n = 0; n < 300; n++) begin
      relock(ok);
      if (!ok) break;
      hp_x = 3; hp_y = 490;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin tick(); if (sync_err) got = 1'b1; end
      hp_x = -1; hp_y = -1;
      if (!got) break;
      seen++;
      if (n == 254) c255 = int'(err_count);
    end
    total++; if (seen != 300) begin bad++; $display("FAIL sat_inject: got %0d errors want 300", seen); end
    total++; if (c255 != 255) begin bad++; $display("FAIL sat_255: got %0d want 255", c255); end
    total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_final: got %0d want 255", err_count); end
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; video_on = 1'b0;
    test_reset();
    test_lock();
    test_de();
    test_hsync_extra();
    test_hsync_late();
    test_vsync_spurious();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
